// File: rtl/word_serializer_2_1_pkg.sv
// word_serializer_2_1_pkg: shared FSM encoding and width rule for N:1 serializers
package word_serializer_2_1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } ser_state_t;

  function automatic bit widths_ok(int width, int in_width, int out_width);
    return (in_width == 2 * width) && (out_width == width);
  endfunction

endpackage

// File: rtl/word_serializer_2_1_mux.sv
// mux_2_1: picks one WIDTH-bit half of a packed double-width word
module mux_2_1 #(
  parameter int WIDTH     = 8,
  parameter int IN_WIDTH  = 2 * WIDTH,
  parameter int OUT_WIDTH = WIDTH
) (
  input  logic                 sel,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0] data_out
);

  // sel=1 drives the upper half
  always_comb data_out = sel ? data_in[WIDTH+:WIDTH] : data_in[0+:WIDTH];

endmodule

// File: rtl/word_serializer_2_1.sv
// word_serializer_2_1: splits a held double-width word into two valid/ready beats
module word_serializer_2_1
  import word_serializer_2_1_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IN_WIDTH  = 2 * WIDTH,
  parameter int OUT_WIDTH = WIDTH,
  parameter int HI_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_half_only,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sel,
  output logic                 out_last
);

  localparam logic HF = (HI_FIRST != 0);

  if (!widths_ok(WIDTH, IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
    $error("word_serializer_2_1: IN_WIDTH must be 2*WIDTH and OUT_WIDTH must be WIDTH");
  end

  ser_state_t          r_state;
  ser_state_t          w_next;
  logic [IN_WIDTH-1:0] r_hold;
  logic                r_half;
  logic                r_sel;
  logic                w_sel_next;
  logic                w_fire;
  logic                w_accept;

  // Handshake decode; in_ready never looks at in_valid
  always_comb begin
    out_valid = (r_state != ST_IDLE);
    out_last  = (r_state == ST_SECOND) | ((r_state == ST_FIRST) & r_half);
    w_fire    = out_valid & out_ready;
    in_ready  = (r_state == ST_IDLE) | (w_fire & out_last);
    w_accept  = in_valid & in_ready;
    out_sel   = r_sel;
  end

  // Next state and select: a new word restarts at the first half, a non-final beat flips halves
  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    if (w_accept) begin
      w_next     = ST_FIRST;
      w_sel_next = HF;
    end else if (w_fire) begin
      w_next     = out_last ? ST_IDLE : ST_SECOND;
      w_sel_next = out_last ? r_sel : ~r_sel;
    end
  end

  // State and select registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= HF;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_next;
    end
  end

  // Holding register, written only on an input handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_half <= 1'b0;
    end else if (w_accept) begin
      r_hold <= in_data;
      r_half <= in_half_only;
    end
  end

  mux_2_1 #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_mux (
    .sel     (r_sel),
    .data_in (r_hold),
    .data_out(out_data)
  );

endmodule

// File: tb/tb_word_serializer_2_1.sv
// tb_word_serializer_2_1: random and directed check of both beat orders against a beat-queue model
module tb_word_serializer_2_1;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_half_only;
  logic        out_ready;
  logic [15:0] in_data;
  logic        ir[2];
  logic        ov[2];
  logic        os[2];
  logic        ol[2];
  logic [7:0]  od[2];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance 0 emits the low half first, instance 1 the high half first
  for (genvar g = 0; g < 2; g++) begin : m
    beat_t q[$];

    word_serializer_2_1 #(.WIDTH(8), .HI_FIRST(g)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (ir[g]),
      .in_data     (in_data),
      .in_half_only(in_half_only),
      .out_valid   (ov[g]),
      .out_ready   (out_ready),
      .out_data    (od[g]),
      .out_sel     (os[g]),
      .out_last    (ol[g])
    );

    // Model: each accepted word queues its beats; outputs must match the queue head
    always @(negedge clk) begin
      beat_t b;
      if (reset) q.delete();
      else begin
        chk($sformatf("m%0d.out_valid", g), ov[g], q.size() != 0);
        chk($sformatf("m%0d.in_ready", g), ir[g], q.size() == 0 || (q.size() == 1 && out_ready));
        if (ov[g] && q.size() != 0) begin
          chk($sformatf("m%0d.out_data", g), od[g], q[0].d);
          chk($sformatf("m%0d.out_sel", g), os[g], q[0].s);
          chk($sformatf("m%0d.out_last", g), ol[g], q[0].l);
          if (out_ready) void'(q.pop_front());
        end
        if (in_valid && ir[g]) begin
          b.d = (g == 1) ? in_data[15:8] : in_data[7:0];
          b.s = (g == 1);
          b.l = in_half_only;
          q.push_back(b);
          if (!in_half_only) begin
            b.d = (g == 1) ? in_data[7:0] : in_data[15:8];
            b.s = (g != 1);
            b.l = 1'b1;
            q.push_back(b);
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_half_only = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", ov[0], 0);
    chk("rst.out_last", ol[0], 0);
    chk("rst.out_sel0", os[0], 0);
    chk("rst.out_sel1", os[1], 1);
    chk("rst.out_data0", od[0], 0);
    chk("rst.out_data1", od[1], 0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready", ir[0], 1);

    // Basic split
    in_valid = 1; in_data = 16'hBEEF; out_ready = 1;
    step(); in_valid = 0;
    chk("basic.b0", od[0], 8'hEF); chk("basic.s0", os[0], 0); chk("basic.l0", ol[0], 0);
    chk("basic.v0", ov[0], 1);
    chk("hif.b0", od[1], 8'hBE); chk("hif.s0", os[1], 1); chk("hif.l0", ol[1], 0);
    step();
    chk("basic.b1", od[0], 8'hBE); chk("basic.s1", os[0], 1); chk("basic.l1", ol[0], 1);
    chk("hif.b1", od[1], 8'hEF); chk("hif.s1", os[1], 0); chk("hif.l1", ol[1], 1);
    step();
    chk("basic.idle", ov[0], 0);

    // Back-to-back
    in_valid = 1; in_data = 16'h1234;
    step(); in_data = 16'h5678;
    chk("b2b.b0", od[0], 8'h34); chk("b2b.ir0", ir[0], 0);
    step();
    chk("b2b.b1", od[0], 8'h12); chk("b2b.ir1", ir[0], 1);
    step(); in_valid = 0;
    chk("b2b.b2", od[0], 8'h78);
    step();
    chk("b2b.b3", od[0], 8'h56);
    step();

    // Backpressure in FIRST
    in_valid = 1; in_data = 16'hF00D; out_ready = 0;
    step(); in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.data", od[0], 8'h0D); chk("bp.sel", os[0], 0); chk("bp.ir", ir[0], 0);
      step();
    end
    out_ready = 1;
    step();
    chk("bp.b1", od[0], 8'hF0); chk("bp.l1", ol[0], 1);
    step();

    // Half-only words on consecutive cycles
    in_valid = 1; in_data = 16'hAA55; in_half_only = 1;
    step(); in_data = 16'hCC33;
    chk("ho.b0", od[0], 8'h55); chk("ho.l0", ol[0], 1); chk("ho.ir", ir[0], 1);
    step(); in_valid = 0; in_half_only = 0;
    chk("ho.b1", od[0], 8'h33); chk("ho.l1", ol[0], 1);
    step();
    chk("ho.idle", ov[0], 0);

    // Reset mid-word
    in_valid = 1; in_data = 16'h1234;
    step(); in_valid = 0;
    chk("rm.b0", od[0], 8'h34);
    step();
    reset = 1;
    #1;
    chk("rm.valid", ov[0], 0);
    chk("rm.data", od[0], 0);
    step(); reset = 0;
    in_valid = 1; in_data = 16'h9A9B;
    step(); in_valid = 0;
    chk("rm.n0", od[0], 8'h9B);
    step();
    chk("rm.n1", od[0], 8'h9A);
    step();

    // Random traffic with random backpressure
    in_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && ir[0];
      step();
      if (acc || !in_valid) begin
        in_valid     = ($urandom_range(0, 2) != 0);
        in_data      = 16'($urandom);
        in_half_only = ($urandom_range(0, 3) == 0);
      end
    end
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_serializer_2_1.md
Name: word_serializer_2_1

Overview:
- Upstream feeder for the 2:1 slice mux.
- Accepts one packed double-width word on a valid/ready handshake and holds it in a register.
- Drives the mux select through a small FSM so the two WIDTH-bit halves leave on a WIDTH-bit valid/ready stream, one half per handshake.
- Used where fusion-unit operand buses are narrower than the buffer read port; optional half-only mode emits just one half for low-precision operands.

Parameters:
- WIDTH, 8: data width of one output slice.
- IN_WIDTH, 2*WIDTH: packed input width; must equal 2*WIDTH.
- OUT_WIDTH, WIDTH: output width; must equal WIDTH.
- HI_FIRST, 0: 0 emits bits [WIDTH-1:0] first; 1 emits bits [2*WIDTH-1:WIDTH] first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_WIDTH  packed word: two WIDTH-bit halves.
- in_half_only  input  1  sampled with in_data; 1 = emit only the first half.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_WIDTH  current slice, taken from the holding register via the mux.
- out_sel  output  1  select currently driving the mux (1 = upper half).
- out_last  output  1  current beat is the final beat of its word.

Behaviour:
- Reset (asynchronous, active-high; values hold while reset is asserted):
  - state=IDLE, hold_reg=0, half_only_reg=0, sel=HI_FIRST.
  - out_valid=0, out_last=0, out_sel=HI_FIRST, out_data=hold_reg slice=0.
  - in_ready=1 once reset deasserts.
- FSM states: IDLE, FIRST, SECOND.
  - IDLE: in_ready=1. On in_valid: capture in_data into hold_reg, in_half_only into half_only_reg; sel=HI_FIRST; go to FIRST.
  - FIRST: out_valid=1, out_last=half_only_reg. When out_ready=1:
    - half_only_reg=0: sel flips, go to SECOND.
    - half_only_reg=1: beat ends the word; apply the "last beat" rule.
  - SECOND: out_valid=1, out_last=1, sel=!HI_FIRST. When out_ready=1, apply the "last beat" rule.
  - Last-beat rule: if in_valid is also 1, capture the new word, sel=HI_FIRST, go to FIRST. Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). Combinational from state and out_ready; no combinational path from in_valid.
- Latency: word accepted at edge N, first beat valid in cycle N+1.
- Throughput:
  - Full words: 1 word per 2 cycles with out_ready held high.
  - half_only words: 1 word per cycle, no bubbles.
- Stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_last hold. hold_reg is written only on an input handshake.
- out_data = sel ? hold_reg[WIDTH+:WIDTH] : hold_reg[0+:WIDTH]. Pure slice selection, no arithmetic, no width change.
- Boundary cases:
  - Stall in FIRST or SECOND: no state change; in_ready=0 (except the last-beat case above).
  - in_valid asserted while busy and not on the last beat: ignored. Upstream must hold it, per the handshake.
  - Reset mid-word: the partially sent word is dropped; no further beats of it appear.
  - out_ready=1 while out_valid=0: no effect.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, FIRST=2'd1, SECOND=2'd2) and the width-check rule IN_WIDTH==2*WIDTH, so a future N:1 serializer reuses them.
- One sub-module: instantiate mux_2_1 (WIDTH, IN_WIDTH, OUT_WIDTH) for slice selection, with sel = registered select and data_in = hold_reg.
- FSM, handshake and registers live in this block.

Test Plan (WIDTH=8, HI_FIRST=0 unless stated):
- Basic split: in_data=16'hBEEF, half_only=0, out_ready=1 -> beats 8'hEF (sel=0, last=0) then 8'hBE (sel=1, last=1), at cycles N+1 and N+2.
- Back-to-back: 16'h1234 then 16'h5678 with in_valid held high -> stream 34,12,78,56 with no bubbles; in_ready high only on the last-beat cycles.
- Half-only: 16'hAA55 with half_only=1, then 16'hCC33 with half_only=1 -> beats 55 (last=1) then 33 (last=1) on consecutive cycles; upper halves never emitted.
- Backpressure: 16'hF00D with out_ready=0 for 3 cycles in FIRST -> out_data stays 8'h0D and out_sel stays 0 for all 3; in_ready=0; then 8'hF0 after release.
- HI_FIRST=1: 16'hBEEF -> beats BE (sel=1) then EF (sel=0, last=1).
- Reset mid-word: assert reset after the first beat of 16'h1234 -> out_valid=0 immediately; after release, new word 16'h9A9B emits 9B then 9A; byte 12 never appears.
